seq_pattern_gen: RTL and testbench

Serial bit-pattern transmitter, the stimulus side of the team's Mealy serial sequence detectors. Captures a PAT_W-bit pattern (default 4'b1010), a repeat count and an inter-pattern gap on a start pulse. Shifts the pattern out MSB-first, one bit per clock, with optional filler gaps and a stall input. Emits a last_bit marker aligned exactly to the cycle a Mealy detector for that pattern must fire, so the block doubles as a golden reference in detector benches.

---
 rtl/seq_pkg.sv | 17 +
 rtl/seq_gen_shifter.sv | 37 +++
 rtl/seq_pattern_gen.sv | 126 ++++++++++++
 tb/tb_seq_pattern_gen.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// seq_pkg: shared state encoding, reference pattern and default widths for the
// serial pattern generator and the Mealy sequence detectors it drives.
package seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } seq_state_e;

    localparam logic [3:0] PAT_1010  = 4'b1010;
    localparam int         PAT_W_DEF = 4;
    localparam int         CNT_W_DEF = 8;
    localparam int         GAP_W_DEF = 4;

endpackage

// File: rtl/seq_gen_shifter.sv
// seq_gen_shifter: parallel-load, shift-left pattern register with a bit index;
// exposes the bit currently on the line (MSB) and whether it is the last one.
module seq_gen_shifter #(
    parameter int PAT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic [PAT_W-1:0] din,
    output logic             msb,
    output logic             idx_zero
);
    localparam int IW = $clog2(PAT_W);

    logic [PAT_W-1:0] sr_q, sr_d;
    logic [IW-1:0]    idx_q, idx_d;

    always_comb begin
        sr_d  = load ? din : shift ? {sr_q[PAT_W-2:0], 1'b0} : sr_q;
        idx_d = load ? IW'(PAT_W - 1) : shift ? idx_q - IW'(1) : idx_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q  <= '0;
            idx_q <= '0;
        end else begin
            sr_q  <= sr_d;
            idx_q <= idx_d;
        end
    end

    assign msb      = sr_q[PAT_W-1];
    assign idx_zero = (idx_q == '0);

endmodule

// File: rtl/seq_pattern_gen.sv
// seq_pattern_gen: serial pattern transmitter with repeat count, filler gaps and
// stall; last_bit marks the cycle a Mealy detector for the pattern must fire.
module seq_pattern_gen
    import seq_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int GAP_W = GAP_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [CNT_W-1:0] repeat_cnt,
    input  logic [GAP_W-1:0] gap_len,
    input  logic             gap_bit,
    input  logic             stall,
    output logic             out,
    output logic             out_valid,
    output logic             last_bit,
    output logic             busy,
    output logic             done
);
    seq_state_e       state_q, state_d;
    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [GAP_W-1:0] gap_len_q, gap_len_d;
    logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
    logic             gap_bit_q, gap_bit_d;
    logic             valid_q, valid_d;
    logic             sh_load, sh_shift, sh_msb, sh_zero;
    logic [PAT_W-1:0] sh_din;

    seq_gen_shifter #(.PAT_W(PAT_W)) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .load     (sh_load),
        .shift    (sh_shift),
        .din      (sh_din),
        .msb      (sh_msb),
        .idx_zero (sh_zero)
    );

    // valid_d marks that the element becoming current is a fresh transmission;
    // a stalled cycle re-presents the same element with valid low.
    always_comb begin
        state_d   = state_q;
        pattern_d = pattern_q;
        rem_d     = rem_q;
        gap_len_d = gap_len_q;
        gap_cnt_d = gap_cnt_q;
        gap_bit_d = gap_bit_q;
        valid_d   = 1'b0;
        sh_load   = 1'b0;
        sh_shift  = 1'b0;
        sh_din    = pattern_q;
        case (state_q)
            IDLE: if (start) begin
                pattern_d = pattern;
                rem_d     = repeat_cnt;
                gap_len_d = gap_len;
                gap_bit_d = gap_bit;
                sh_load   = 1'b1;
                sh_din    = pattern;
                state_d   = (repeat_cnt != '0) ? SEND : DONE;
                valid_d   = (repeat_cnt != '0);
            end
            SEND: if (!stall) begin
                if (!sh_zero) begin
                    sh_shift = 1'b1;
                    valid_d  = 1'b1;
                end else begin
                    rem_d = (rem_q != '0) ? rem_q - CNT_W'(1) : rem_q;
                    if (rem_d == '0) begin
                        state_d = DONE;
                    end else if (gap_len_q != '0) begin
                        state_d   = GAP;
                        gap_cnt_d = gap_len_q - GAP_W'(1);
                        valid_d   = 1'b1;
                    end else begin
                        sh_load = 1'b1;
                        valid_d = 1'b1;
                    end
                end
            end
            GAP: if (!stall) begin
                valid_d = 1'b1;
                if (gap_cnt_q == '0) begin
                    state_d = SEND;
                    sh_load = 1'b1;
                end else begin
                    gap_cnt_d = gap_cnt_q - GAP_W'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            rem_q     <= '0;
            gap_len_q <= '0;
            gap_cnt_q <= '0;
            gap_bit_q <= 1'b0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            rem_q     <= rem_d;
            gap_len_q <= gap_len_d;
            gap_cnt_q <= gap_cnt_d;
            gap_bit_q <= gap_bit_d;
            valid_q   <= valid_d;
        end
    end

    assign out       = (state_q == SEND) ? sh_msb : ((state_q == GAP) && gap_bit_q);
    assign out_valid = valid_q;
    assign last_bit  = valid_q && (state_q == SEND) && sh_zero;
    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);

endmodule

// File: tb/tb_seq_pattern_gen.sv
// tb_seq_pattern_gen: directed scenarios for seq_pattern_gen; expected vectors are
// {check_out, out, out_valid, last_bit, busy, done} per cycle after start (cycle 0).
module tb_seq_pattern_gen;
    import seq_pkg::*;

    localparam int PW = 4;
    localparam int CW = 8;
    localparam int GW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          gap_bit = 1'b0;
    logic          stall = 1'b0;
    logic [PW-1:0] pattern = '0;
    logic [CW-1:0] repeat_cnt = '0;
    logic [GW-1:0] gap_len = '0;
    logic          out, out_valid, last_bit, busy, done;
    int            pass_cnt = 0;
    int            total_cnt = 0;
    logic [5:0]    e [32];

    always #5 clk = ~clk;

    seq_pattern_gen #(.PAT_W(PW), .CNT_W(CW), .GAP_W(GW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pattern    (pattern),
        .repeat_cnt (repeat_cnt),
        .gap_len    (gap_len),
        .gap_bit    (gap_bit),
        .stall      (stall),
        .out        (out),
        .out_valid  (out_valid),
        .last_bit   (last_bit),
        .busy       (busy),
        .done       (done)
    );

    task automatic launch(input logic [PW-1:0] p, input logic [CW-1:0] r,
                          input logic [GW-1:0] g, input logic gb);
        @(posedge clk); #1;
        pattern = p; repeat_cnt = r; gap_len = g; gap_bit = gb; start = 1'b1;
    endtask

    task automatic test_reset;
        #1 rst = 1'b0;
        #1;
        total_cnt++;
        if ({out, out_valid, last_bit, busy, done} !== 5'b0)
            $display("FAIL reset_async got %b%b%b%b%b want 00000", out, out_valid, last_bit, busy, done);
        else pass_cnt++;
        start = 1'b1; repeat_cnt = 8'd1;
        @(posedge clk); #1;
        total_cnt++;
        if ({out, out_valid, last_bit, busy, done} !== 5'b0)
            $display("FAIL reset_held got %b%b%b%b%b want 00000", out, out_valid, last_bit, busy, done);
        else pass_cnt++;
        start = 1'b0;
        @(negedge clk) rst = 1'b1;
    endtask

    task automatic test_single;
        logic [3:0] p = PAT_1010;
        for (int k = 1; k <= 4; k++) e[k] = {1'b1, p[4-k], 1'b1, k == 4, 1'b1, 1'b0};
        e[5] = 6'b000011;
        e[6] = 6'b100000;
        launch(p, 8'd1, 4'd0, 1'b0);
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            total_cnt++;
            if ({out_valid, last_bit, busy, done} !== e[k][3:0] || (e[k][5] && out !== e[k][4]))
                $display("FAIL single cyc%0d got o/v/l/b/d=%b%b%b%b%b want %b", k, out, out_valid, last_bit, busy, done, e[k][4:0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back;
        logic [3:0] p = PAT_1010;
        for (int k = 1; k <= 12; k++) e[k] = {1'b1, p[3-((k-1)%4)], 1'b1, (k % 4) == 0, 1'b1, 1'b0};
        e[13] = 6'b000011;
        e[14] = 6'b100000;
        launch(p, 8'd3, 4'd0, 1'b0);
        for (int k = 1; k <= 14; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            total_cnt++;
            if ({out_valid, last_bit, busy, done} !== e[k][3:0] || (e[k][5] && out !== e[k][4]))
                $display("FAIL b2b cyc%0d got o/v/l/b/d=%b%b%b%b%b want %b", k, out, out_valid, last_bit, busy, done, e[k][4:0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_gap;
        logic [3:0] p = PAT_1010;
        logic [3:0] q = 4'b1100;
        for (int k = 1; k <= 4; k++) begin
            e[k]   = {1'b1, p[4-k], 1'b1, k == 4, 1'b1, 1'b0};
            e[k+6] = {1'b1, p[4-k], 1'b1, k == 4, 1'b1, 1'b0};
        end
        e[5] = 6'b101010; e[6] = 6'b101010; e[11] = 6'b000011; e[12] = 6'b100000;
        launch(p, 8'd2, 4'd2, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            if (k == 1) begin pattern = 4'b0101; repeat_cnt = 8'd9; gap_len = 4'd7; gap_bit = 1'b1; end
            total_cnt++;
            if ({out_valid, last_bit, busy, done} !== e[k][3:0] || (e[k][5] && out !== e[k][4]))
                $display("FAIL gap2 cyc%0d got o/v/l/b/d=%b%b%b%b%b want %b", k, out, out_valid, last_bit, busy, done, e[k][4:0]);
            else pass_cnt++;
        end
        for (int k = 1; k <= 4; k++) begin
            e[k]   = {1'b1, q[4-k], 1'b1, k == 4, 1'b1, 1'b0};
            e[k+5] = {1'b1, q[4-k], 1'b1, k == 4, 1'b1, 1'b0};
        end
        e[5] = 6'b111010; e[10] = 6'b000011; e[11] = 6'b100000;
        launch(q, 8'd2, 4'd1, 1'b1);
        for (int k = 1; k <= 11; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            total_cnt++;
            if ({out_valid, last_bit, busy, done} !== e[k][3:0] || (e[k][5] && out !== e[k][4]))
                $display("FAIL gap1 cyc%0d got o/v/l/b/d=%b%b%b%b%b want %b", k, out, out_valid, last_bit, busy, done, e[k][4:0]);
            else pass_cnt++;
        end
    endtask

    task automatic test_stall;
        e[1] = 6'b111010; e[2] = 6'b110010; e[3] = 6'b110010; e[4] = 6'b101010;
        e[5] = 6'b111010; e[6] = 6'b101110; e[7] = 6'b000011; e[8] = 6'b100000;
        launch(PAT_1010, 8'd1, 4'd0, 1'b0);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            stall = (k == 1 || k == 2);
            total_cnt++;
            if ({out_valid, last_bit, busy, done} !== e[k][3:0] || (e[k][5] && out !== e[k][4]))
                $display("FAIL stall cyc%0d got o/v/l/b/d=%b%b%b%b%b want %b", k, out, out_valid, last_bit, busy, done, e[k][4:0]);
            else pass_cnt++;
        end
        stall = 1'b0;
    endtask

    task automatic test_zero_repeat;
        launch(PAT_1010, 8'd0, 4'd0, 1'b0);
        @(posedge clk); #1;
        repeat_cnt = 8'd1;
        total_cnt++;
        if ({out_valid, last_bit, busy, done} !== 4'b0011)
            $display("FAIL zero_done got v/l/b/d=%b%b%b%b want 0011", out_valid, last_bit, busy, done);
        else pass_cnt++;
        for (int k = 2; k <= 3; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            total_cnt++;
            if ({out, out_valid, last_bit, busy, done} !== 5'b0)
                $display("FAIL zero_ignore cyc%0d got o/v/l/b/d=%b%b%b%b%b want 00000", k, out, out_valid, last_bit, busy, done);
            else pass_cnt++;
        end
    endtask

    task automatic test_mid_reset;
        logic [3:0] p = 4'b0110;
        launch(PAT_1010, 8'd3, 4'd0, 1'b0);
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk); #5;
        total_cnt++;
        if ({out, out_valid, busy} !== 3'b111)
            $display("FAIL pre_abort got o/v/b=%b%b%b want 111", out, out_valid, busy);
        else pass_cnt++;
        rst = 1'b0;
        #1;
        total_cnt++;
        if ({out, out_valid, last_bit, busy, done} !== 5'b0)
            $display("FAIL abort got o/v/l/b/d=%b%b%b%b%b want 00000", out, out_valid, last_bit, busy, done);
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if ({out, out_valid, last_bit, busy, done} !== 5'b0)
            $display("FAIL abort_hold got o/v/l/b/d=%b%b%b%b%b want 00000", out, out_valid, last_bit, busy, done);
        else pass_cnt++;
        rst = 1'b1;
        pattern = p; repeat_cnt = 8'd1; gap_len = 4'd0; gap_bit = 1'b0; start = 1'b1;
        for (int k = 1; k <= 4; k++) e[k] = {1'b1, p[4-k], 1'b1, k == 4, 1'b1, 1'b0};
        e[5] = 6'b000011;
        e[6] = 6'b100000;
        for (int k = 1; k <= 6; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            total_cnt++;
            if ({out_valid, last_bit, busy, done} !== e[k][3:0] || (e[k][5] && out !== e[k][4]))
                $display("FAIL restart cyc%0d got o/v/l/b/d=%b%b%b%b%b want %b", k, out, out_valid, last_bit, busy, done, e[k][4:0]);
            else pass_cnt++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_gap();
        test_stall();
        test_zero_repeat();
        test_mid_reset();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
